// File: rtl/range_pkg.sv
// Shared definitions for the range sample framer: the framer state type,
// the default sample width and a small sizing helper.
// Optional feature macro used by the framer: RANGE_FRAMER_TIMEOUT_EN.
package range_pkg;

  localparam int RANGE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } framer_state_t;

  // Number of host bytes that make up one sample of the given width.
  function automatic int range_bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/range_byte_assembler.sv
// Little-endian byte packer: the first byte of a word lands in bits [7:0].
// word_out/word_done are combinational views of the word that the current
// byte completes, so the caller can register the sample on the same edge
// that samples the final byte. clear drops any partial bytes and wins over
// a byte presented in the same cycle.
module range_byte_assembler
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_done
);

  localparam int NB = range_bytes_per_word(WIDTH);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] buf_r;
  logic [WIDTH-1:0] merged_s;

  // Drop the incoming byte into the lane selected by the byte index.
  always_comb begin
    merged_s = buf_r;
    for (int i = 0; i < NB; i++) begin
      if (idx_r == IW'(i)) begin
        merged_s[8*i +: 8] = byte_in;
      end else begin
        merged_s[8*i +: 8] = buf_r[8*i +: 8];
      end
    end
  end

  assign word_out  = merged_s;
  assign word_done = byte_valid && (idx_r == LAST_IDX);

  // Hold partial bytes and advance the byte index; wrap after the last lane.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      idx_r <= {IW{1'b0}};
      buf_r <= {WIDTH{1'b0}};
    end else if (byte_valid) begin
      buf_r <= merged_s;
      if (idx_r == LAST_IDX) begin
        idx_r <= {IW{1'b0}};
      end else begin
        idx_r <= idx_r + IW'(1);
      end
    end else begin
      idx_r <= idx_r;
      buf_r <= buf_r;
    end
  end

endmodule

// File: rtl/range_sample_framer.sv
// Frames host bytes into WIDTH-bit samples: go marks the first sample of a
// frame, finish marks the frame close (IDLE -> ACTIVE -> DRAIN -> FINISH).
// Optional macro RANGE_FRAMER_TIMEOUT_EN adds an idle counter that closes an
// ACTIVE frame after TIMEOUT_CYCLES cycles without a byte; without it the
// timeout output is tied low.
module range_sample_framer
  import range_pkg::*;
#(
  parameter int WIDTH          = RANGE_WIDTH,
  parameter int MAX_SAMPLES    = 255,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             frame_end,
  output logic [WIDTH-1:0] data_out,
  output logic             sample_strobe,
  output logic             go,
  output logic             finish,
  output logic [7:0]       sample_count,
  output logic             frame_error,
  output logic             timeout
);

  if ((WIDTH % 8) != 0 || WIDTH < 8 || MAX_SAMPLES < 1 || MAX_SAMPLES > 255 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("range_sample_framer: illegal parameter set");
  end

  localparam logic [7:0] MAX_CNT = 8'(MAX_SAMPLES);

  framer_state_t    state_r;
  framer_state_t    next_state_s;
  logic [WIDTH-1:0] data_out_r;
  logic             sample_strobe_r;
  logic             go_r;
  logic             finish_r;
  logic [7:0]       sample_count_r;
  logic             frame_error_r;

  logic             asm_valid_s;
  logic             asm_clear_s;
  logic [WIDTH-1:0] word_s;
  logic             word_done_s;
  logic             take_word_s;
  logic             first_word_s;
  logic             error_s;
  logic [7:0]       next_count_s;
  logic             idle_hit_s;

  range_byte_assembler #(.WIDTH(WIDTH)) u_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear_s),
    .byte_in    (byte_in),
    .byte_valid (asm_valid_s),
    .word_out   (word_s),
    .word_done  (word_done_s)
  );

  // Bytes are accepted in ACTIVE, and in IDLE unless the host is closing.
  always_comb begin
    if (byte_valid && (state_r == ACTIVE || (state_r == IDLE && !frame_end))) begin
      asm_valid_s = 1'b1;
    end else begin
      asm_valid_s = 1'b0;
    end
  end

  // Frame sequencing: next state, sample capture, counting and errors.
  always_comb begin
    next_state_s = state_r;
    asm_clear_s  = 1'b0;
    take_word_s  = 1'b0;
    first_word_s = 1'b0;
    error_s      = 1'b0;
    next_count_s = sample_count_r;
    case (state_r)
      IDLE: begin
        if (frame_end) begin
          asm_clear_s = 1'b1;
          error_s     = 1'b1;
        end else if (word_done_s) begin
          take_word_s  = 1'b1;
          first_word_s = 1'b1;
          next_count_s = 8'd1;
          if (MAX_CNT == 8'd1) begin
            next_state_s = DRAIN;
          end else begin
            next_state_s = ACTIVE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (word_done_s) begin
          take_word_s  = 1'b1;
          next_count_s = sample_count_r + 8'd1;
        end else begin
          next_count_s = sample_count_r;
        end
        if (frame_end || next_count_s == MAX_CNT || idle_hit_s) begin
          next_state_s = DRAIN;
          asm_clear_s  = 1'b1;
        end else begin
          next_state_s = ACTIVE;
        end
      end
      DRAIN: begin
        error_s      = byte_valid;
        next_state_s = FINISH;
      end
      FINISH: begin
        error_s      = byte_valid;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Registered state and outputs; data_out only moves on a strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= IDLE;
      data_out_r      <= {WIDTH{1'b0}};
      sample_strobe_r <= 1'b0;
      go_r            <= 1'b0;
      finish_r        <= 1'b0;
      sample_count_r  <= 8'd0;
      frame_error_r   <= 1'b0;
    end else begin
      state_r         <= next_state_s;
      if (take_word_s) begin
        data_out_r <= word_s;
      end else begin
        data_out_r <= data_out_r;
      end
      sample_strobe_r <= take_word_s;
      go_r            <= first_word_s;
      finish_r        <= (next_state_s == FINISH);
      sample_count_r  <= next_count_s;
      frame_error_r   <= error_s;
    end
  end

`ifdef RANGE_FRAMER_TIMEOUT_EN
  logic [31:0] idle_cnt_r;
  logic        timeout_r;

  assign idle_hit_s = (state_r == ACTIVE) && !byte_valid &&
                      (idle_cnt_r == 32'(TIMEOUT_CYCLES - 1));

  // Count consecutive byte-less ACTIVE cycles; pulse when the frame auto-closes.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt_r <= 32'd0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= idle_hit_s && !frame_end;
      if (state_r != ACTIVE || byte_valid || idle_hit_s) begin
        idle_cnt_r <= 32'd0;
      end else begin
        idle_cnt_r <= idle_cnt_r + 32'd1;
      end
    end
  end

  assign timeout = timeout_r;
`else
  assign idle_hit_s = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign data_out      = data_out_r;
  assign sample_strobe = sample_strobe_r;
  assign go            = go_r;
  assign finish        = finish_r;
  assign sample_count  = sample_count_r;
  assign frame_error   = frame_error_r;

endmodule

// File: tb/tb_range_sample_framer.sv
// Bench for range_sample_framer (WIDTH=16, MAX_SAMPLES=3, TIMEOUT_CYCLES=8).
// Directed scenarios followed by random traffic, all checked every cycle
// against a frame-level reference model built from byte queues.
// Honours RANGE_FRAMER_TIMEOUT_EN when defined.
module tb_range_sample_framer;

  localparam int WIDTH = 16;
  localparam int NB    = WIDTH / 8;
  localparam int MAXS  = 3;
  localparam int TOC   = 8;
`ifdef RANGE_FRAMER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             frame_end;
  logic [WIDTH-1:0] data_out;
  logic             sample_strobe;
  logic             go;
  logic             finish;
  logic [7:0]       sample_count;
  logic             frame_error;
  logic             timeout;

  range_sample_framer #(
    .WIDTH(WIDTH), .MAX_SAMPLES(MAXS), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .frame_end(frame_end), .data_out(data_out), .sample_strobe(sample_strobe),
    .go(go), .finish(finish), .sample_count(sample_count),
    .frame_error(frame_error), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a frame is open after its first word; closing counts
  // down the two post-close cycles (2 = draining, 1 = finishing).
  logic [7:0]       m_q[$];
  bit               m_open = 1'b0;
  int               m_closing = 0;
  int               m_count = 0;
  int               m_idle = 0;
  logic [WIDTH-1:0] m_data = '0;
  bit e_strobe, e_go, e_fin, e_err, e_to;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic emit_word();
    m_data = '0;
    for (int i = 0; i < NB; i++) m_data = m_data | (WIDTH'(m_q[i]) << (8 * i));
    m_q.delete();
    e_strobe = 1'b1;
  endtask

  task automatic model_step(input bit rst, input bit bv, input logic [7:0] b, input bit fe);
    bit to_hit;
    to_hit = 1'b0;
    e_strobe = 0; e_go = 0; e_fin = 0; e_err = 0; e_to = 0;
    if (rst) begin
      m_open = 0; m_closing = 0; m_count = 0; m_idle = 0; m_data = '0; m_q.delete();
    end else if (m_closing == 2) begin
      e_err = bv; m_closing = 1; e_fin = 1;
    end else if (m_closing == 1) begin
      e_err = bv; m_closing = 0; m_open = 0;
    end else if (!m_open) begin
      if (fe) begin
        e_err = 1; m_q.delete();
      end else if (bv) begin
        m_q.push_back(b);
        if (m_q.size() == NB) begin
          emit_word(); e_go = 1; m_count = 1; m_open = 1; m_idle = 0;
          if (m_count == MAXS) m_closing = 2;
        end
      end
    end else begin
      if (bv) begin
        m_q.push_back(b); m_idle = 0;
        if (m_q.size() == NB) begin emit_word(); m_count++; end
      end else begin
        m_idle++;
        if (TO_EN && m_idle == TOC) to_hit = 1;
      end
      if (fe || m_count == MAXS || to_hit) begin
        e_to = to_hit && !fe; m_closing = 2; m_q.delete(); m_idle = 0;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit bv, input logic [7:0] b, input bit fe);
    reset = rst; byte_valid = bv; byte_in = b; frame_end = fe;
    @(posedge clock);
    model_step(rst, bv, b, fe);
    #1;
    check_value("data_out", 32'(data_out), 32'(m_data));
    check_value("sample_strobe", 32'(sample_strobe), 32'(e_strobe));
    check_value("go", 32'(go), 32'(e_go));
    check_value("finish", 32'(finish), 32'(e_fin));
    check_value("sample_count", 32'(sample_count), 32'(m_count));
    check_value("frame_error", 32'(frame_error), 32'(e_err));
    check_value("timeout", 32'(timeout), 32'(e_to));
    check_value("go_finish_excl", 32'(go & finish), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; frame_end = 1'b0;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h55, 1'b1);
    check_value("reset_data", 32'(data_out), 32'd0);
    check_value("reset_count", 32'(sample_count), 32'd0);
    idle_cycles(2);

    // Two words then a host close.
    cycle(1'b0, 1'b1, 8'h34, 1'b0);
    cycle(1'b0, 1'b1, 8'h12, 1'b0);
    check_value("s1_word0", 32'(data_out), 32'h1234);
    check_value("s1_go", 32'(go), 32'd1);
    cycle(1'b0, 1'b1, 8'h10, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check_value("s1_word1", 32'(data_out), 32'h0010);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_value("s1_finish", 32'(finish), 32'd1);
    check_value("s1_count", 32'(sample_count), 32'd2);
    idle_cycles(2);

    // Final byte and frame_end together.
    cycle(1'b0, 1'b1, 8'hCD, 1'b0);
    cycle(1'b0, 1'b1, 8'hAB, 1'b0);
    cycle(1'b0, 1'b1, 8'h78, 1'b0);
    cycle(1'b0, 1'b1, 8'h56, 1'b1);
    check_value("s2_last", 32'(data_out), 32'h5678);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_value("s2_finish", 32'(finish), 32'd1);
    idle_cycles(2);

    // frame_end in IDLE with a partial byte.
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_value("s3_error", 32'(frame_error), 32'd1);
    cycle(1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check_value("s3_word", 32'(data_out), 32'h0001);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle_cycles(3);

    // Stream four words into a three-sample frame.
    for (int i = 0; i < 4 * NB; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    idle_cycles(3);

    // Reset in the middle of an active frame.
    for (int i = 0; i < 2 * NB; i++) cycle(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check_value("s5_count", 32'(sample_count), 32'd0);
    idle_cycles(3);

    // One word then silence.
    cycle(1'b0, 1'b1, 8'h11, 1'b0);
    cycle(1'b0, 1'b1, 8'h22, 1'b0);
    idle_cycles(TOC + 4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
            8'($urandom_range(0, 255)), $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
